ling_pipe_adder: RTL and testbench



---
 rtl/ling_pipe_adder_pkg.sv | 16 +
 rtl/ling_pipe_adder_group_gen.sv | 35 +++
 rtl/ling_pipe_adder.sv | 158 +++++++++++++++
 tb/tb_ling_pipe_adder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ling_pipe_adder_pkg.sv
// Shared constants, sizing helper and group-result type for the pipelined Ling adder.
package ling_pkg;

  localparam int LING_STAGES = 3;

  function automatic int ngrp(input int width, input int group);
    return width / group;
  endfunction

  // Registered per-group lookahead result carried from level one to level two.
  typedef struct packed {
    logic hg;
    logic tg;
  } grp_gt_t;

endpackage

// File: rtl/ling_pipe_adder_group_gen.sv
// Combinational N-bit Ling lookahead generator: group generate, group transmit and
// zero-carry-in pseudo-carries h[k] = g[k] | (carry into bit k).
module ling_group_gen
  import ling_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] g,
  input  logic [N-1:0] t,
  output logic         hg,
  output logic         tg,
  output logic [N-1:0] h
);

  // Sum-of-products form keeps each pseudo-carry a single AND-OR level.
  always_comb begin
    logic acc;
    logic tr;
    h = '0;
    for (int k = 0; k < N; k++) begin
      acc = g[k];
      tr  = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        acc = acc | (tr & g[j]);
        tr  = tr & t[j];
      end
      h[k] = acc;
    end
  end

  assign hg = t[N-1] & h[N-1];
  // Folding hg into the transmit keeps g -> t true, so the generator nests at level two.
  assign tg = hg | (&t);

endmodule

// File: rtl/ling_pipe_adder.sv
// Three-stage pipelined two-level Ling adder/subtractor with valid/ready on both sides.
module ling_pipe_adder
  import ling_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = ngrp(WIDTH, GROUP);

  if ((WIDTH % GROUP) != 0) begin : g_width_chk
    $error("ling_pipe_adder: WIDTH must be a multiple of GROUP");
  end

  logic vld_p0, vld_p1, vld_p2;
  logic rdy_p0, rdy_p1, rdy_p2;

  logic [WIDTH-1:0] a_p0, b_p0;
  logic             cin_p0;

  logic [WIDTH-1:0] g_p1, t_p1, p_p1;
  logic             cin_p1;
  logic [NGRP-1:0]  hg_c1, tg_c1;
  logic [WIDTH-1:0] h_c1;

  logic [WIDTH-1:0]         t_p2, p_p2, h_p2;
  logic                     cin_p2;
  grp_gt_t [NGRP-1:0]       grp_p2;
  logic [NGRP-1:0]          hg_p2v, tg_p2v;
  logic                     hg_l2, tg_l2;
  logic [NGRP-1:0]          h_l2;
  logic [NGRP-1:0]          gcin;
  logic [WIDTH:0]           c;
  logic                     unused_l2;

  assign rdy_p2    = !vld_p2 || out_ready;
  assign rdy_p1    = !vld_p1 || rdy_p2;
  assign rdy_p0    = !vld_p0 || rdy_p1;
  assign in_ready  = rdy_p0;
  assign out_valid = vld_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (rdy_p0) vld_p0 <= in_valid;
      if (rdy_p1) vld_p1 <= vld_p0;
      if (rdy_p2) vld_p2 <= vld_p1;
    end
  end

  // S0: operand capture, b inverted for subtract
  always_ff @(posedge clk) begin
    if (rdy_p0) begin
      a_p0   <= a;
      b_p0   <= sub ? ~b : b;
      cin_p0 <= cin;
    end
  end

  // S1: per-bit generate/transmit/propagate, first-level group lookahead
  always_ff @(posedge clk) begin
    if (rdy_p1) begin
      g_p1   <= a_p0 & b_p0;
      t_p1   <= a_p0 | b_p0;
      p_p1   <= a_p0 ^ b_p0;
      cin_p1 <= cin_p0;
    end
  end

  for (genvar j = 0; j < NGRP; j++) begin : g_l1
    ling_group_gen #(.N(GROUP)) u_grp (
      .g  (g_p1[j*GROUP +: GROUP]),
      .t  (t_p1[j*GROUP +: GROUP]),
      .hg (hg_c1[j]),
      .tg (tg_c1[j]),
      .h  (h_c1[j*GROUP +: GROUP])
    );
  end

  // S2: second-level lookahead, carry recovery and result
  always_ff @(posedge clk) begin
    if (rdy_p2) begin
      t_p2   <= t_p1;
      p_p2   <= p_p1;
      h_p2   <= h_c1;
      cin_p2 <= cin_p1;
      for (int j = 0; j < NGRP; j++) begin
        grp_p2[j] <= '{hg: hg_c1[j], tg: tg_c1[j]};
      end
    end
  end

  always_comb begin
    hg_p2v = '0;
    tg_p2v = '0;
    for (int j = 0; j < NGRP; j++) begin
      hg_p2v[j] = grp_p2[j].hg;
      tg_p2v[j] = grp_p2[j].tg;
    end
  end

  ling_group_gen #(.N(NGRP)) u_l2 (
    .g  (hg_p2v),
    .t  (tg_p2v),
    .hg (hg_l2),
    .tg (tg_l2),
    .h  (h_l2)
  );

  // The whole-word generate/transmit is subsumed by the bit-level recovery of c[WIDTH].
  assign unused_l2 = ^{hg_l2, tg_l2, h_l2[NGRP-1]};

  always_comb begin
    logic tall;
    gcin    = '0;
    tall    = 1'b1;
    gcin[0] = cin_p2;
    for (int j = 1; j < NGRP; j++) begin
      tall    = tall & tg_p2v[j-1];
      gcin[j] = (tg_p2v[j-1] & h_l2[j-1]) | (tall & cin_p2);
    end
  end

  // Real pseudo-carry is the local one widened by the group carry-in over the transmit prefix.
  always_comb begin
    logic tpre;
    c    = '0;
    tpre = 1'b1;
    c[0] = cin_p2;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i % GROUP) == 0) tpre = 1'b1;
      c[i+1] = t_p2[i] & (h_p2[i] | (tpre & gcin[i/GROUP]));
      tpre   = tpre & t_p2[i];
    end
  end

  assign sum  = p_p2 ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];
  assign ovf  = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: tb/tb_ling_pipe_adder.sv
// Directed bench for ling_pipe_adder: latency, subtract, streaming, stall, reset and width sweep.
module tb_ling_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, sub, cout, ovf;

  logic        sw_valid, sw_cin, sw_sub, sw_ordy;
  logic [63:0] sw_a, sw_b;
  logic        s8_ir, s8_ov, s8_cout, s8_ovf;
  logic [7:0]  s8_sum;
  logic        s16_ir, s16_ov, s16_cout, s16_ovf;
  logic [15:0] s16_sum;
  logic        s24_ir, s24_ov, s24_cout, s24_ovf;
  logic [23:0] s24_sum;
  logic        s64_ir, s64_ov, s64_cout, s64_ovf;
  logic [63:0] s64_sum;

  int checks = 0;
  int passed = 0;
  int outcnt = 0;
  int acc    = 0;
  int cyc    = 0;
  int first_out, last_out;
  logic [65:0] expq[$];
  logic [65:0] saved;

  always #5 clk = ~clk;

  ling_pipe_adder #(.WIDTH(32), .GROUP(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  ling_pipe_adder #(.WIDTH(8), .GROUP(4)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s8_ir), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .cin(sw_cin), .sub(sw_sub), .out_valid(s8_ov), .out_ready(sw_ordy), .sum(s8_sum),
    .cout(s8_cout), .ovf(s8_ovf)
  );

  ling_pipe_adder #(.WIDTH(16), .GROUP(4)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s16_ir), .a(sw_a[15:0]), .b(sw_b[15:0]),
    .cin(sw_cin), .sub(sw_sub), .out_valid(s16_ov), .out_ready(sw_ordy), .sum(s16_sum),
    .cout(s16_cout), .ovf(s16_ovf)
  );

  ling_pipe_adder #(.WIDTH(24), .GROUP(8)) u_w24 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s24_ir), .a(sw_a[23:0]), .b(sw_b[23:0]),
    .cin(sw_cin), .sub(sw_sub), .out_valid(s24_ov), .out_ready(sw_ordy), .sum(s24_sum),
    .cout(s24_cout), .ovf(s24_ovf)
  );

  ling_pipe_adder #(.WIDTH(64), .GROUP(4)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s64_ir), .a(sw_a), .b(sw_b),
    .cin(sw_cin), .sub(sw_sub), .out_valid(s64_ov), .out_ready(sw_ordy), .sum(s64_sum),
    .cout(s64_cout), .ovf(s64_ovf)
  );

  // Reference: plain (w+1)-bit addition of a, b' and cin; overflow from operand/result signs.
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input logic s, input int w);
    logic [63:0] m, xm, yb;
    logic [64:0] r;
    logic        co, ov;
    m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm = x & m;
    yb = (s ? ~y : y) & m;
    r  = {1'b0, xm} + {1'b0, yb} + {64'd0, ci};
    co = r[w];
    ov = (xm[w-1] == yb[w-1]) && (r[w-1] != xm[w-1]);
    return {co, ov, r[63:0] & m};
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: sample and score the output, then drive the next beat and the output ready.
  task automatic step(input logic ordy, input logic iv, input logic [31:0] ia,
                      input logic [31:0] ib, input logic ic, input logic is);
    @(posedge clk);
    #1;
    cyc++;
    out_ready = ordy;
    if (out_valid) begin
      if (expq.size() == 0) begin
        chk("spurious_out", {65'd0, out_valid}, 66'd0);
      end else begin
        chk($sformatf("result_%0d", outcnt), {cout, ovf, 32'd0, sum}, expq[0]);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (ordy) begin
          void'(expq.pop_front());
          outcnt++;
        end
      end
    end
    in_valid = iv;
    a        = ia;
    b        = ib;
    cin      = ic;
    sub      = is;
    if (iv && in_ready) begin
      expq.push_back(model({32'd0, ia}, {32'd0, ib}, ic, is, 32));
      acc++;
    end
  endtask

  task automatic sw_chk(input string tag, input int w, input int k, input logic v,
                        input logic [63:0] s, input logic co, input logic ov);
    if (k < w) begin
      chk($sformatf("%s_k%0d_vld", tag, k), {65'd0, v}, 66'd1);
      chk($sformatf("%s_k%0d", tag, k), {co, ov, s}, model(sw_a, sw_b, sw_cin, 1'b0, w));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_ordy = 1'b1;
    first_out = -1; last_out = -1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {65'd0, out_valid}, 66'd0);
    chk("rst_in_ready", {65'd0, in_ready}, 66'd1);
    chk("rst_w64_out_valid", {65'd0, s64_ov}, 66'd0);
    rst = 1'b0;

    // Latency and carry ripple through every group: 0xFFFFFFFF + 1
    step(1, 1, 32'hFFFF_FFFF, 32'h1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("lat_edge1", {65'd0, out_valid}, 66'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("lat_edge2", {65'd0, out_valid}, 66'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("lat_edge3", {65'd0, out_valid}, 66'd1);
    chk("add_ones_plus1", {cout, ovf, 32'd0, sum}, {1'b1, 1'b0, 64'h0});
    step(1, 0, 0, 0, 0, 0);
    chk("lat_gone", {65'd0, out_valid}, 66'd0);

    // Subtract across the signed boundary: 0x80000000 - 1
    step(1, 1, 32'h8000_0000, 32'h1, 1, 1);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    chk("sub_min_vld", {65'd0, out_valid}, 66'd1);
    chk("sub_min", {cout, ovf, 32'd0, sum}, {1'b1, 1'b1, 64'h7FFF_FFFF});
    step(1, 0, 0, 0, 0, 0);

    // Back-to-back stream of 100 random beats
    outcnt = 0; first_out = -1; last_out = -1;
    for (int i = 0; i < 100; i++) begin
      step(1, 1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (4) step(1, 0, 0, 0, 0, 0);
    chk("stream_count", 66'(outcnt), 66'd100);
    chk("stream_span", 66'(last_out - first_out), 66'd99);

    // Backpressure: three beats fill the pipe, then in_ready drops
    outcnt = 0; acc = 0;
    step(0, 1, 32'h1234_5678, 32'h0FED_CBA9, 0, 0);
    step(0, 1, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0);
    step(0, 1, 32'h0000_0005, 32'h0000_0007, 1, 1);
    step(0, 1, 32'hDEAD_BEEF, 32'h1111_1111, 0, 0);
    saved = {cout, ovf, 32'd0, sum};
    step(0, 1, 32'hDEAD_BEEF, 32'h1111_1111, 0, 0);
    step(0, 1, 32'hDEAD_BEEF, 32'h1111_1111, 0, 0);
    chk("stall_accepted", 66'(acc), 66'd3);
    chk("stall_in_ready", {65'd0, in_ready}, 66'd0);
    chk("stall_sum_stable", {cout, ovf, 32'd0, sum}, saved);
    repeat (4) step(1, 0, 0, 0, 0, 0);
    chk("stall_drained", 66'(outcnt), 66'd3);

    // Reset with two beats in flight
    step(1, 1, 32'hAAAA_AAAA, 32'h5555_5555, 1, 0);
    step(1, 1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {65'd0, out_valid}, 66'd0);
    chk("midrst_in_ready", {65'd0, in_ready}, 66'd1);
    expq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      step(1, 0, 0, 0, 0, 0);
      chk("postrst_idle", {65'd0, out_valid}, 66'd0);
    end
    step(1, 1, 32'h0000_00FF, 32'h0000_0001, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("postrst_lat2", {65'd0, out_valid}, 66'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("postrst_lat3", {65'd0, out_valid}, 66'd1);
    chk("postrst_value", {cout, ovf, 32'd0, sum}, {1'b0, 1'b0, 64'h100});
    step(1, 0, 0, 0, 0, 0);

    // Carry-chain sweep over several WIDTH/GROUP shapes: all-ones + (1 << k)
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      sw_a = '1; sw_b = 64'd1 << k; sw_cin = k[0]; sw_valid = 1'b1;
      @(posedge clk);
      #1 sw_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sw_chk("w8g4",  8,  k, s8_ov,  {56'd0, s8_sum},  s8_cout,  s8_ovf);
      sw_chk("w16g4", 16, k, s16_ov, {48'd0, s16_sum}, s16_cout, s16_ovf);
      sw_chk("w24g8", 24, k, s24_ov, {40'd0, s24_sum}, s24_cout, s24_ovf);
      sw_chk("w64g4", 64, k, s64_ov, s64_sum,          s64_cout, s64_ovf);
    end

    chk("queue_empty", 66'(expq.size()), 66'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
